// File: rtl/wb_splitter_pkg.sv
// Shared types and helpers for the Wishbone code/data memory splitter.
package wb_splitter_pkg;

  localparam int TIMER_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    TGT_CODE,
    TGT_DATA
  } target_t;

  // One registered master-side request, as presented to a memory slave.
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
  } wb_req_t;

  localparam wb_req_t WB_REQ_NONE = '0;

  function automatic logic is_data_addr(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/wb_mem_splitter.sv
// Routes one classic Wishbone master to code (m0) or data (m1) memory by
// address decode, with registered slave requests, registered ack and timeout.
module wb_mem_splitter
  import wb_splitter_pkg::*;
#(
  parameter logic [31:0] DATA_BASE      = 32'h8000_0000,
  parameter logic [31:0] DATA_MASK      = 32'hF000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  input  logic [3:0]  s_sel_i,
  input  logic [31:0] s_addr_i,
  input  logic [31:0] s_data_i,
  output logic [31:0] s_data_o,
  output logic        s_ack_o,
  output logic        s_err_o,

  output logic        m0_cyc_o,
  output logic        m0_stb_o,
  output logic        m0_we_o,
  output logic [3:0]  m0_sel_o,
  output logic [31:0] m0_addr_o,
  output logic [31:0] m0_data_o,
  input  logic [31:0] m0_data_i,
  input  logic        m0_ack_i,

  output logic        m1_cyc_o,
  output logic        m1_stb_o,
  output logic        m1_we_o,
  output logic [3:0]  m1_sel_o,
  output logic [31:0] m1_addr_o,
  output logic [31:0] m1_data_o,
  input  logic [31:0] m1_data_i,
  input  logic        m1_ack_i
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

  state_t               state;
  target_t              target;
  wb_req_t              m0_req;
  wb_req_t              m1_req;
  logic [TIMER_W-1:0]   timer;
  logic [31:0]          rdata_q;
  logic                 ack_q;
  logic                 err_q;

  wb_req_t              new_req;
  logic                 sel_ack;
  logic                 sel_we;
  logic [31:0]          sel_rdata;

  always_comb begin
    new_req      = WB_REQ_NONE;
    new_req.cyc  = 1'b1;
    new_req.stb  = 1'b1;
    new_req.we   = s_we_i;
    new_req.sel  = s_sel_i;
    new_req.addr = s_addr_i;
    new_req.data = s_data_i;
  end

  // Only the port latched at request time is listened to; the other ack is ignored.
  always_comb begin
    sel_ack   = 1'b0;
    sel_we    = 1'b0;
    sel_rdata = '0;
    if (target == TGT_DATA) begin
      sel_ack   = m1_ack_i;
      sel_we    = m1_req.we;
      sel_rdata = m1_data_i;
    end else begin
      sel_ack   = m0_ack_i;
      sel_we    = m0_req.we;
      sel_rdata = m0_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      target  <= TGT_CODE;
      m0_req  <= WB_REQ_NONE;
      m1_req  <= WB_REQ_NONE;
      timer   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (s_cyc_i && s_stb_i) begin
            timer <= '0;
            state <= ACCESS;
            if (is_data_addr(s_addr_i, DATA_BASE, DATA_MASK)) begin
              target <= TGT_DATA;
              m1_req <= new_req;
            end else begin
              target <= TGT_CODE;
              m0_req <= new_req;
            end
          end
        end

        ACCESS: begin
          // Abort beats ack; ack beats a timeout expiring on the same edge.
          if (!s_cyc_i) begin
            m0_req <= WB_REQ_NONE;
            m1_req <= WB_REQ_NONE;
            state  <= IDLE;
          end else if (sel_ack) begin
            m0_req  <= WB_REQ_NONE;
            m1_req  <= WB_REQ_NONE;
            rdata_q <= sel_we ? 32'h0 : sel_rdata;
            ack_q   <= 1'b1;
            state   <= RESP;
          end else if (timer >= TIMER_LAST) begin
            m0_req  <= WB_REQ_NONE;
            m1_req  <= WB_REQ_NONE;
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= RESP;
          end else if (timer != TIMER_MAX) begin
            timer <= timer + 1'b1;
          end
        end

        RESP: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          state <= IDLE;
        end

        default: begin
          m0_req <= WB_REQ_NONE;
          m1_req <= WB_REQ_NONE;
          ack_q  <= 1'b0;
          err_q  <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign s_data_o  = rdata_q;
  assign s_ack_o   = ack_q;
  assign s_err_o   = err_q;

  assign m0_cyc_o  = m0_req.cyc;
  assign m0_stb_o  = m0_req.stb;
  assign m0_we_o   = m0_req.we;
  assign m0_sel_o  = m0_req.sel;
  assign m0_addr_o = m0_req.addr;
  assign m0_data_o = m0_req.data;

  assign m1_cyc_o  = m1_req.cyc;
  assign m1_stb_o  = m1_req.stb;
  assign m1_we_o   = m1_req.we;
  assign m1_sel_o  = m1_req.sel;
  assign m1_addr_o = m1_req.addr;
  assign m1_data_o = m1_req.data;

  a_ack_err_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(s_ack_o && s_err_o));
  a_one_port_active: assert property (@(posedge clk) disable iff (rst)
    !(m0_cyc_o && m1_cyc_o));

endmodule

// File: tb/tb_wb_mem_splitter.sv
// Scoreboard bench for wb_mem_splitter: directed transfers push expected
// responses, a monitor pops and compares whenever ack or err appears.
module tb_wb_mem_splitter;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_cyc_i = 1'b0, s_stb_i = 1'b0, s_we_i = 1'b0;
  logic [3:0]  s_sel_i = '0;
  logic [31:0] s_addr_i = '0, s_data_i = '0;
  logic [31:0] s_data_o;
  logic        s_ack_o, s_err_o;
  logic        m0_cyc_o, m0_stb_o, m0_we_o, m0_ack_i;
  logic [3:0]  m0_sel_o;
  logic [31:0] m0_addr_o, m0_data_o, m0_data_i;
  logic        m1_cyc_o, m1_stb_o, m1_we_o, m1_ack_i;
  logic [3:0]  m1_sel_o;
  logic [31:0] m1_addr_o, m1_data_o, m1_data_i;

  wb_mem_splitter #(
    .DATA_BASE(32'h8000_0000), .DATA_MASK(32'hF000_0000), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_sel_i(s_sel_i),
    .s_addr_i(s_addr_i), .s_data_i(s_data_i), .s_data_o(s_data_o),
    .s_ack_o(s_ack_o), .s_err_o(s_err_o),
    .m0_cyc_o(m0_cyc_o), .m0_stb_o(m0_stb_o), .m0_we_o(m0_we_o), .m0_sel_o(m0_sel_o),
    .m0_addr_o(m0_addr_o), .m0_data_o(m0_data_o), .m0_data_i(m0_data_i), .m0_ack_i(m0_ack_i),
    .m1_cyc_o(m1_cyc_o), .m1_stb_o(m1_stb_o), .m1_we_o(m1_we_o), .m1_sel_o(m1_sel_o),
    .m1_addr_o(m1_addr_o), .m1_data_o(m1_data_o), .m1_data_i(m1_data_i), .m1_ack_i(m1_ack_i)
  );

  always #5 clk = ~clk;

  // Slave models: ack when the strobe has been high for dly+1 cycles.
  logic [7:0]  dly0 = '0, dly1 = '0, cnt0 = '0, cnt1 = '0;
  logic        never0 = 1'b0, never1 = 1'b0, stray0 = 1'b0;
  logic [31:0] rdata0 = '0, rdata1 = '0;

  always @(posedge clk) begin
    cnt0 <= m0_stb_o ? 8'(cnt0 + 1) : 8'd0;
    cnt1 <= m1_stb_o ? 8'(cnt1 + 1) : 8'd0;
  end

  assign m0_ack_i  = (m0_cyc_o && m0_stb_o && !never0 && cnt0 == dly0) || stray0;
  assign m1_ack_i  = m1_cyc_o && m1_stb_o && !never1 && cnt1 == dly1;
  assign m0_data_i = rdata0;
  assign m1_data_i = rdata1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          err;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] port_bits(input int p);
    if (p == 0)
      return m0_addr_o | m0_data_o | {25'b0, m0_cyc_o, m0_stb_o, m0_we_o, m0_sel_o};
    return m1_addr_o | m1_data_o | {25'b0, m1_cyc_o, m1_stb_o, m1_we_o, m1_sel_o};
  endfunction

  function automatic logic [31:0] all_outputs();
    return port_bits(0) | port_bits(1) | s_data_o | {30'b0, s_ack_o, s_err_o};
  endfunction

  // Response monitor: every ack/err must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (s_ack_o || s_err_o)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_resp: got ack=%b err=%b expected none", s_ack_o, s_err_o);
        end else begin
          e = exp_q.pop_front();
          check_output("resp_ack", {31'b0, s_ack_o}, {31'b0, !e.err});
          check_output("resp_err", {31'b0, s_err_o}, {31'b0, e.err});
          check_output("resp_data", s_data_o, e.data);
        end
      end
    end
  end

  // One complete core transfer; call at a negedge with the DUT in IDLE.
  task automatic apply_stimulus(input string name, input logic we, input logic [3:0] sel,
                                input logic [31:0] addr, input logic [31:0] data,
                                input int port, input int exp_lat,
                                input bit exp_err, input logic [31:0] exp_data);
    exp_t e;
    int   waited;
    bit   done;
    e.err  = exp_err;
    e.data = exp_data;
    exp_q.push_back(e);
    waited   = 0;
    done     = 0;
    s_cyc_i  = 1'b1;
    s_stb_i  = 1'b1;
    s_we_i   = we;
    s_sel_i  = sel;
    s_addr_i = addr;
    s_data_i = data;
    while (!done && waited < 64) begin
      @(negedge clk);
      waited++;
      if (waited == 1) begin
        if (port == 0) begin
          check_output({name, "_ctl"}, {28'b0, m0_cyc_o, m0_stb_o, m0_we_o, 1'b0} | {28'b0, m0_sel_o},
                       {28'b0, 1'b1, 1'b1, we, 1'b0} | {28'b0, sel});
          check_output({name, "_addr"}, m0_addr_o, addr);
          check_output({name, "_wdata"}, m0_data_o, data);
        end else begin
          check_output({name, "_ctl"}, {28'b0, m1_cyc_o, m1_stb_o, m1_we_o, 1'b0} | {28'b0, m1_sel_o},
                       {28'b0, 1'b1, 1'b1, we, 1'b0} | {28'b0, sel});
          check_output({name, "_addr"}, m1_addr_o, addr);
          check_output({name, "_wdata"}, m1_data_o, data);
        end
      end
      check_output({name, "_other_idle"}, port_bits(1 - port), 32'h0);
      if (s_ack_o || s_err_o) done = 1;
    end
    check_output({name, "_latency"}, 32'(waited), 32'(exp_lat));
    check_output({name, "_port_dropped"}, port_bits(port) & 32'h0000_0060, 32'h0);
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    s_we_i  = 1'b0;
    @(negedge clk);
    check_output({name, "_pulse_once"}, {30'b0, s_ack_o, s_err_o}, 32'h0);
    check_output({name, "_data_hold"}, s_data_o, exp_data);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_output("reset_outputs", all_outputs(), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    rdata0 = 32'h1234_5678; dly0 = 8'd0;
    apply_stimulus("code_read", 1'b0, 4'hF, 32'h0000_0010, 32'h0, 0, 2, 1'b0, 32'h1234_5678);

    dly1 = 8'd3;
    apply_stimulus("data_write", 1'b1, 4'b0011, 32'h8000_0004, 32'hCAFE_BABE, 1, 5, 1'b0, 32'h0);

    never0 = 1'b1;
    apply_stimulus("timeout", 1'b0, 4'hF, 32'h0000_0100, 32'h0, 0, T + 1, 1'b1, 32'h0);
    never0 = 1'b0; dly0 = 8'd1; rdata0 = 32'hA5A5_0001;
    apply_stimulus("after_timeout", 1'b0, 4'hF, 32'h0000_0104, 32'h0, 0, 3, 1'b0, 32'hA5A5_0001);

    dly1 = 8'(T - 1); rdata1 = 32'h0BAD_F00D;
    apply_stimulus("collision", 1'b0, 4'hF, 32'h8000_0040, 32'h0, 1, T + 1, 1'b0, 32'h0BAD_F00D);
    dly1 = 8'(T);
    apply_stimulus("one_late", 1'b0, 4'hF, 32'h8000_0044, 32'h0, 1, T + 1, 1'b1, 32'h0);

    // Abort two cycles into ACCESS, then a stray ack while idle.
    never0 = 1'b1;
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_addr_i = 32'h0000_0020; s_sel_i = 4'hF;
    @(negedge clk);
    check_output("abort_started", {31'b0, m0_cyc_o}, 32'h1);
    @(negedge clk);
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    @(negedge clk);
    check_output("abort_dropped", {30'b0, m0_cyc_o, m0_stb_o}, 32'h0);
    stray0 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_output("stray_ignored", {30'b0, s_ack_o, s_err_o}, 32'h0);
    end
    stray0 = 1'b0; never0 = 1'b0;
    @(negedge clk);

    dly0 = 8'd0; dly1 = 8'd0;
    rdata0 = 32'h1111_0000;
    apply_stimulus("b2b_code0", 1'b0, 4'hF, 32'h0000_0000, 32'h0, 0, 2, 1'b0, 32'h1111_0000);
    rdata1 = 32'h2222_0001;
    apply_stimulus("b2b_data", 1'b0, 4'hF, 32'h8000_0000, 32'h0, 1, 2, 1'b0, 32'h2222_0001);
    rdata0 = 32'h3333_0004;
    apply_stimulus("b2b_code4", 1'b0, 4'hF, 32'h0000_0004, 32'h0, 0, 2, 1'b0, 32'h3333_0004);

    // Asynchronous reset between edges while a data access is pending.
    never1 = 1'b1;
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_addr_i = 32'h8000_0100;
    repeat (2) @(negedge clk);
    check_output("pre_reset_active", {31'b0, m1_stb_o}, 32'h1);
    #2 rst = 1'b1;
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    #1 check_output("async_reset_clear", all_outputs(), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("post_reset_idle", all_outputs(), 32'h0);
    never1 = 1'b0; dly1 = 8'd2; rdata1 = 32'h4444_5555;
    apply_stimulus("post_reset_read", 1'b0, 4'hF, 32'h8000_0200, 32'h0, 1, 4, 1'b0, 32'h4444_5555);

    repeat (3) @(negedge clk);
    check_output("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
